// File: rtl/uart_pkg.sv
// Shared definitions for the ASCII hex line loader: character codes, parser states
// and the hex-nibble decode used by the digit classifier.
package uart_pkg;

    localparam logic [7:0] SP  = 8'h20;
    localparam logic [7:0] TAB = 8'h09;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;

    typedef enum logic [2:0] {
        PRE_ADDR = 3'd0,
        ADDR     = 3'd1,
        GAP      = 3'd2,
        DATA     = 3'd3,
        TAIL     = 3'd4,
        SKIP     = 3'd5
    } parse_state_e;

    // Returns {is_hex, nibble}; nibble is zero when the byte is not a hex digit.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= "0" && c <= "9")      r = {1'b1, 4'(c - 8'h30)};
        else if (c >= "a" && c <= "f") r = {1'b1, 4'(c - 8'h57)};
        else if (c >= "A" && c <= "F") r = {1'b1, 4'(c - 8'h37)};
        return r;
    endfunction

endpackage

// File: rtl/uart_hex_digit.sv
// Combinational classifier for one received ASCII byte: hex digit, whitespace or
// end-of-line, plus the decoded nibble value.
module uart_hex_digit
    import uart_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic       is_hex_o,
    output logic       is_space_o,
    output logic       is_eol_o,
    output logic [3:0] nibble_o
);

    logic [4:0] dec;

    always_comb begin
        dec        = hex_nibble(ch_i);
        is_hex_o   = dec[4];
        nibble_o   = dec[3:0];
        is_space_o = (ch_i == SP) || (ch_i == TAB);
        is_eol_o   = (ch_i == CR) || (ch_i == LF);
    end

endmodule

// File: rtl/uart_hex_loader.sv
// Parses "addr data" hex lines from a UART byte stream into 32-bit write requests.
// One-cycle latency from the EOL byte to wr_valid; a commit while the output is busy is dropped with err.
module uart_hex_loader
    import uart_pkg::*;
#(
    parameter int unsigned max_digits = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        err,
    output logic [15:0] line_count
);

    localparam logic [3:0] MAX_CNT = 4'(max_digits);

    logic         is_hex, is_space, is_eol;
    logic [3:0]   nibble;

    parse_state_e state_q, state_d;
    logic [31:0]  acc_q, acc_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic         wr_valid_q, wr_valid_d;
    logic [31:0]  wr_addr_q, wr_addr_d;
    logic [31:0]  wr_data_q, wr_data_d;
    logic         err_q, err_d;
    logic [15:0]  line_count_q, line_count_d;

    logic         commit;
    logic         out_free;

    uart_hex_digit u_digit (
        .ch_i       (byte_data),
        .is_hex_o   (is_hex),
        .is_space_o (is_space),
        .is_eol_o   (is_eol),
        .nibble_o   (nibble)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        line_count_d = line_count_q;
        err_d        = 1'b0;
        commit       = 1'b0;
        out_free     = !wr_valid_q || wr_ready;

        if (byte_ready) begin
            unique case (state_q)
                PRE_ADDR: begin
                    if (is_hex) begin
                        acc_d   = {28'd0, nibble};
                        cnt_d   = 4'd1;
                        state_d = ADDR;
                    end else if (!is_space && !is_eol) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
                ADDR, DATA: begin
                    if (is_hex) begin
                        // A digit beyond the field width poisons the rest of the line.
                        if (cnt_q < MAX_CNT) begin
                            acc_d = {acc_q[27:0], nibble};
                            cnt_d = cnt_q + 4'd1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = SKIP;
                        end
                    end else if (is_space) begin
                        if (state_q == ADDR) begin
                            addr_d  = acc_q;
                            state_d = GAP;
                        end else begin
                            state_d = TAIL;
                        end
                    end else if (is_eol) begin
                        if (state_q == ADDR) err_d = 1'b1;
                        else                 commit = 1'b1;
                        state_d = PRE_ADDR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
                GAP: begin
                    if (is_hex) begin
                        acc_d   = {28'd0, nibble};
                        cnt_d   = 4'd1;
                        state_d = DATA;
                    end else if (is_eol) begin
                        err_d   = 1'b1;
                        state_d = PRE_ADDR;
                    end else if (!is_space) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
                TAIL: begin
                    if (is_eol) begin
                        commit  = 1'b1;
                        state_d = PRE_ADDR;
                    end else if (!is_space) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (is_eol) state_d = PRE_ADDR;
                end
                default: state_d = PRE_ADDR;
            endcase
        end

        if (commit && out_free) begin
            wr_valid_d   = 1'b1;
            wr_addr_d    = addr_q;
            wr_data_d    = acc_q;
            line_count_d = line_count_q + 16'd1;
        end else begin
            if (commit) err_d = 1'b1;
            if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= PRE_ADDR;
            acc_q        <= 32'd0;
            cnt_q        <= 4'd0;
            addr_q       <= 32'd0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 32'd0;
            wr_data_q    <= 32'd0;
            err_q        <= 1'b0;
            line_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
            line_count_q <= line_count_d;
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign err        = err_q;
    assign line_count = line_count_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader: expected writes are queued as lines are sent
// and matched against accepted writes; error pulses and line counts checked per scenario.
module tb_uart_hex_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        err;
    logic [15:0] line_count;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int vld_cyc  = 0;
    logic err_prev = 1'b0;
    logic [63:0] sb[$];

    always #5 clock = ~clock;

    uart_hex_loader #(.max_digits(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .err        (err),
        .line_count (line_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: accepted writes are popped from the scoreboard; err pulses are tallied.
    always @(negedge clock) begin
        logic [63:0] e;
        if (!reset) begin
            if (err) begin
                err_cnt++;
                chk("err_consecutive", {31'd0, err_prev}, 32'd0);
            end
            err_prev = err;
            if (wr_valid) vld_cyc++;
            if (wr_valid && wr_ready) begin
                chk("sb_depth_nonzero", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", wr_addr, e[63:32]);
                    chk("wr_data", wr_data, e[31:0]);
                end
            end
        end else begin
            err_prev = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_ready = 1'b1;
        @(posedge clock); #1;
        byte_ready = 1'b0;
        byte_data  = 8'h00;
        @(posedge clock); #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clock);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_wr_addr", wr_addr, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_line_count", {16'd0, line_count}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);

        // Full-width fields, one single-cycle write
        e0 = err_cnt; vld_cyc = 0;
        sb.push_back({32'h0000_0010, 32'hDEAD_BEEF});
        send_str("00000010 DEADBEEF\n");
        wait_drain();
        idle(3);
        chk("t1_vld_cycles", vld_cyc, 32'd1);
        chk("t1_line_count", {16'd0, line_count}, 32'd1);
        chk("t1_err", err_cnt - e0, 32'd0);

        // Leading whitespace, tab gap, CR LF
        e0 = err_cnt;
        sb.push_back({32'h0000_001F, 32'h0000_0005});
        send_str("  1f\t5\r\n");
        wait_drain();
        idle(3);
        chk("t2_line_count", {16'd0, line_count}, 32'd2);
        chk("t2_err", err_cnt - e0, 32'd0);

        // Nine-digit address overflows
        e0 = err_cnt;
        send_str("123456789 1\n");
        sb.push_back({32'h4, 32'h8});
        send_str("4 8\n");
        wait_drain();
        idle(3);
        chk("t3_err", err_cnt - e0, 32'd1);
        chk("t3_line_count", {16'd0, line_count}, 32'd3);

        // Non-hex character in data field
        e0 = err_cnt;
        send_str("12 G0\n");
        sb.push_back({32'h1, 32'h2});
        send_str("1 2\n");
        wait_drain();
        idle(3);
        chk("t4_err", err_cnt - e0, 32'd1);
        chk("t4_line_count", {16'd0, line_count}, 32'd4);

        // Backpressure: second commit collides with the held write
        e0 = err_cnt;
        wr_ready = 1'b0;
        sb.push_back({32'h1, 32'h2});
        send_str("1 2\n3 4\n");
        idle(3);
        @(negedge clock);
        chk("t5_held_valid", {31'd0, wr_valid}, 32'd1);
        chk("t5_held_addr", wr_addr, 32'h1);
        chk("t5_held_data", wr_data, 32'h2);
        chk("t5_err", err_cnt - e0, 32'd1);
        chk("t5_line_count", {16'd0, line_count}, 32'd5);
        @(posedge clock); #1;
        wr_ready = 1'b1;
        wait_drain();
        idle(3);
        chk("t5_valid_cleared", {31'd0, wr_valid}, 32'd0);
        chk("t5_line_count_after", {16'd0, line_count}, 32'd5);

        // Reset mid-line, with a pending write
        wr_ready = 1'b0;
        sb.push_back({32'h7, 32'h9});
        send_str("7 9\n");
        send_str("0000 12");
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clock);
        chk("t6_rst_valid", {31'd0, wr_valid}, 32'd0);
        chk("t6_rst_addr", wr_addr, 32'd0);
        chk("t6_rst_data", wr_data, 32'd0);
        chk("t6_rst_line_count", {16'd0, line_count}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        wr_ready = 1'b1;
        idle(2);
        e0 = err_cnt;
        sb.push_back({32'h5, 32'h6});
        send_str("5 6\n");
        wait_drain();
        idle(3);
        chk("t6_err", err_cnt - e0, 32'd0);
        chk("t6_line_count", {16'd0, line_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
